// File: rtl/fpnew_pkg.sv
// Shared FPU definitions: floating-point format enumeration, IEEE status
// flags, and a round-robin pointer helper used by the result arbiters.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 5;
    localparam int unsigned FP_FORMAT_BITS = $clog2(NUM_FP_FORMATS);

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 'd0,
        FP64    = 'd1,
        FP16    = 'd2,
        FP8     = 'd3,
        FP16ALT = 'd4
    } fp_format_e;

    typedef struct packed {
        logic NV; // invalid operation
        logic DZ; // divide by zero
        logic OF; // overflow
        logic UF; // underflow
        logic NX; // inexact
    } status_t;

    // Wrapped increment of a round-robin pointer over n entries; explicit
    // wrap so non-power-of-two counts never reach an out-of-range index.
    function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
        if (idx + 1 >= n) return 0;
        return idx + 1;
    endfunction

endpackage

// File: rtl/fpnew_rr_pick.sv
// Combinational round-robin picker.
//   req_i : request vector, element 0 first
//   ptr_i : highest-priority index; scan runs ptr, ptr+1, ..., wrapping
//   gnt_o : one-hot grant of the winner (all zero when nothing requests)
//   idx_o : binary index of the winner
//   any_o : at least one request is active
module fpnew_rr_pick #(
    parameter  int unsigned NumReq   = 5,
    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [0:NumReq-1]   req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [0:NumReq-1]   gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_o
);

    // Walk offsets from farthest to nearest so the request closest to the
    // pointer overwrites any earlier match and wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        for (int unsigned k = NumReq; k > 0; k--) begin
            logic [IdxWidth-1:0] ci;
            ci = IdxWidth'((32'(ptr_i) + k - 1) % NumReq);
            if (req_i[ci]) begin
                idx_o     = ci;
                gnt_o     = '0;
                gnt_o[ci] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpnew_slice_out_arb.sv
// Opgroup result collector: arbitrates round-robin among the format slices
// of one operation group and holds the winner in a single output register.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   result_i .. tag_i    : per-slice result, status, extension bit, tag
//   in_valid_i/in_ready_o: per-slice handshake (at most one ready at a time)
//   flush_i              : drop the held result, accept nothing this cycle
//   result_o .. tag_o    : registered winner fields
//   fmt_idx_o            : slice index that produced the held result
//   out_valid_o/out_ready_i : downstream handshake
//   busy_o               : result held or any slice pending
module fpnew_slice_out_arb
    import fpnew_pkg::*;
#(
    parameter  int unsigned NumInputs = 5,
    parameter  int unsigned Width     = 32,
    parameter  type         TagType   = logic,
    localparam int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [0:NumInputs-1][Width-1:0]   result_i,
    input  status_t [0:NumInputs-1]           status_i,
    input  logic [0:NumInputs-1]              extension_bit_i,
    input  TagType [0:NumInputs-1]            tag_i,
    input  logic [0:NumInputs-1]              in_valid_i,
    output logic [0:NumInputs-1]              in_ready_o,
    input  logic                              flush_i,
    output logic [Width-1:0]                  result_o,
    output status_t                           status_o,
    output logic                              extension_bit_o,
    output TagType                            tag_o,
    output logic [IdxWidth-1:0]               fmt_idx_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic                              busy_o
);

    logic                 valid_q,  valid_d;
    logic [IdxWidth-1:0]  rr_q,     rr_d;
    logic [Width-1:0]     result_q, result_d;
    status_t              status_q, status_d;
    logic                 ext_q,    ext_d;
    TagType               tag_q,    tag_d;
    logic [IdxWidth-1:0]  idx_q,    idx_d;

    logic [0:NumInputs-1] gnt;
    logic [IdxWidth-1:0]  win_idx;
    logic                 any_valid;
    logic                 load;
    logic                 handshake;

    fpnew_rr_pick #(
        .NumReq (NumInputs)
    ) i_pick (
        .req_i (in_valid_i),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (any_valid)
    );

    // The register can take new data when empty or draining this cycle;
    // flush blocks any acceptance.
    assign load       = (!valid_q || out_ready_i) && !flush_i;
    assign handshake  = load && any_valid;
    assign in_ready_o = handshake ? gnt : '0;
    assign busy_o     = valid_q || any_valid;

    always_comb begin
        valid_d  = valid_q;
        rr_d     = rr_q;
        result_d = result_q;
        status_d = status_q;
        ext_d    = ext_q;
        tag_d    = tag_q;
        idx_d    = idx_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = any_valid;
        end

        if (handshake) begin
            result_d = result_i[win_idx];
            status_d = status_i[win_idx];
            ext_d    = extension_bit_i[win_idx];
            tag_d    = tag_i[win_idx];
            idx_d    = win_idx;
            rr_d     = IdxWidth'(rr_next(32'(win_idx), NumInputs));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            rr_q     <= '0;
            result_q <= '0;
            status_q <= '0;
            ext_q    <= 1'b0;
            tag_q    <= '0;
            idx_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            rr_q     <= rr_d;
            result_q <= result_d;
            status_q <= status_d;
            ext_q    <= ext_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
        end
    end

    assign out_valid_o     = valid_q;
    assign result_o        = result_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;
    assign fmt_idx_o       = idx_q;

endmodule

// File: tb/tb_fpnew_slice_out_arb.sv
module tb_fpnew_slice_out_arb;
    import fpnew_pkg::*;

    localparam int unsigned NI = 5;
    typedef logic [7:0] tag_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [0:NI-1][31:0]     result_i;
    status_t [0:NI-1]        status_i;
    logic [0:NI-1]           extension_bit_i;
    tag_t [0:NI-1]           tag_i;
    logic [0:NI-1]           in_valid_i;
    logic [0:NI-1]           in_ready_o;
    logic                    flush_i;
    logic [31:0]             result_o;
    status_t                 status_o;
    logic                    extension_bit_o;
    tag_t                    tag_o;
    logic [2:0]              fmt_idx_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic                    busy_o;

    always #5 clk = ~clk;

    fpnew_slice_out_arb #(
        .NumInputs (NI),
        .Width     (32),
        .TagType   (tag_t)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .result_i        (result_i),
        .status_i        (status_i),
        .extension_bit_i (extension_bit_i),
        .tag_i           (tag_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .flush_i         (flush_i),
        .result_o        (result_o),
        .status_o        (status_o),
        .extension_bit_o (extension_bit_o),
        .tag_o           (tag_o),
        .fmt_idx_o       (fmt_idx_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .busy_o          (busy_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  st;
        logic        ext;
        tag_t        tag;
        int          idx;
    } rec_t;

    typedef struct {
        logic [4:0] v;     // bit i = slice i valid
        logic       ordy;
        logic       fl;
        int         gnt;   // expected granted slice, -1 for none
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    logic m_valid = 1'b0;
    rec_t sb[$];
    vec_t tbl[20];

    function automatic logic [31:0] gen_res(int r, int i);
        if (r == 0 && i == 2) return 32'h3F80_0000;
        return {8'(r), 8'(i), 16'(r * 37 + i * 11)};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [4:0] v, logic ordy, logic fl, int row);
        for (int i = 0; i < NI; i++) begin
            result_i[i]        = gen_res(row, i);
            status_i[i]        = status_t'(5'(row + i));
            extension_bit_i[i] = 1'((row + i) % 2);
            tag_i[i]           = 8'(row * 8 + i);
            in_valid_i[i]      = v[i];
        end
        out_ready_i = ordy;
        flush_i     = fl;
    endtask

    // One clock: drive, check same-cycle ready/busy, update the scoreboard
    // at the edge, then compare the registered output with the queue head.
    task automatic cycle(logic [4:0] v, logic ordy, logic fl, int g, int row, string nm);
        logic [4:0] rdy;
        logic [4:0] exp_rdy;
        logic       ld;
        rec_t       r;
        drive(v, ordy, fl, row);
        #1;
        for (int i = 0; i < NI; i++) rdy[i] = in_ready_o[i];
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({nm, ".ready"}, 32'(rdy), 32'(exp_rdy));
        chk({nm, ".busy"}, 32'(busy_o), 32'(m_valid | (|v)));
        ld = (!m_valid || ordy) && !fl;
        @(posedge clk);
        if (m_valid && (ordy || fl) && sb.size() > 0) r = sb.pop_front();
        if (g >= 0) begin
            r.res = gen_res(row, g);
            r.st  = 5'(row + g);
            r.ext = 1'((row + g) % 2);
            r.tag = 8'(row * 8 + g);
            r.idx = g;
            sb.push_back(r);
        end
        if (fl) m_valid = 1'b0;
        else if (ld) m_valid = (g >= 0);
        #1;
        chk({nm, ".out_valid"}, 32'(out_valid_o), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk({nm, ".sb_nonempty"}, 32'(0), 32'(1));
            end else begin
                chk({nm, ".result"}, result_o, sb[0].res);
                chk({nm, ".status"}, 32'(status_o), 32'(sb[0].st));
                chk({nm, ".ext"}, 32'(extension_bit_o), 32'(sb[0].ext));
                chk({nm, ".tag"}, 32'(tag_o), 32'(sb[0].tag));
                chk({nm, ".fmt_idx"}, 32'(fmt_idx_o), 32'(sb[0].idx));
            end
        end
    endtask

    initial begin
        // reset plan
        tbl[0]  = '{5'b00100, 1'b1, 1'b0, 2};   // single valid, rr -> 3
        tbl[1]  = '{5'b01000, 1'b1, 1'b0, 3};   // rr -> 4
        tbl[2]  = '{5'b10000, 1'b1, 1'b0, 4};   // rr -> 0
        tbl[3]  = '{5'b11111, 1'b1, 1'b0, 0};   // all valid: 0,1,2,3,4,0
        tbl[4]  = '{5'b11111, 1'b1, 1'b0, 1};
        tbl[5]  = '{5'b11111, 1'b1, 1'b0, 2};
        tbl[6]  = '{5'b11111, 1'b1, 1'b0, 3};
        tbl[7]  = '{5'b11111, 1'b1, 1'b0, 4};
        tbl[8]  = '{5'b11111, 1'b1, 1'b0, 0};   // rr -> 1
        tbl[9]  = '{5'b00010, 1'b0, 1'b0, -1};  // stall x4
        tbl[10] = '{5'b00010, 1'b0, 1'b0, -1};
        tbl[11] = '{5'b00010, 1'b0, 1'b0, -1};
        tbl[12] = '{5'b00010, 1'b0, 1'b0, -1};
        tbl[13] = '{5'b00010, 1'b1, 1'b0, 1};   // release: slice 1, rr -> 2
        tbl[14] = '{5'b01000, 1'b1, 1'b0, 3};   // rr -> 4
        tbl[15] = '{5'b10001, 1'b1, 1'b0, 4};   // wrap: rr -> 0
        tbl[16] = '{5'b10001, 1'b1, 1'b0, 0};   // rr -> 1
        tbl[17] = '{5'b01000, 1'b1, 1'b1, -1};  // flush while full
        tbl[18] = '{5'b01000, 1'b0, 1'b0, 3};   // rr still 1 -> slice 3, rr -> 4
        tbl[19] = '{5'b00000, 1'b1, 1'b0, -1};  // drain

        drive(5'b00000, 1'b0, 1'b0, 0);
        #12;
        chk("reset.out_valid", 32'(out_valid_o), 32'(0));
        chk("reset.result", result_o, 32'(0));
        chk("reset.status", 32'(status_o), 32'(0));
        chk("reset.ext", 32'(extension_bit_o), 32'(0));
        chk("reset.tag", 32'(tag_o), 32'(0));
        chk("reset.fmt_idx", 32'(fmt_idx_o), 32'(0));
        chk("reset.busy", 32'(busy_o), 32'(0));
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < 20; r++) begin
            cycle(tbl[r].v, tbl[r].ordy, tbl[r].fl, tbl[r].gnt, r, $sformatf("row%0d", r));
        end

        // rr is 4 here: scan 4,0,1,2 grants slice 2, leaving rr at 3
        cycle(5'b00100, 1'b1, 1'b0, 2, 20, "pre_rst");
        drive(5'b00010, 1'b1, 1'b0, 21);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 32'(out_valid_o), 32'(0));
        chk("async_rst.result", result_o, 32'(0));
        chk("async_rst.fmt_idx", 32'(fmt_idx_o), 32'(0));
        chk("async_rst.busy_in", 32'(busy_o), 32'(1));
        in_valid_i = '0;
        #1;
        chk("async_rst.busy_idle", 32'(busy_o), 32'(0));
        sb.delete();
        m_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // rr back at 0: slice 0 wins over slice 4
        cycle(5'b10001, 1'b1, 1'b0, 0, 22, "post_rst_rr0");
        cycle(5'b00000, 1'b1, 1'b0, -1, 23, "post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
